aurora_64b66b_rx: RTL and testbench

Receive-side parser for the Aurora 64B/66B user-data link that carries PCIe receive-end notifications between boards. It sits on the Aurora core's AXI4-Stream RX user interface, which has no back-pressure. It validates each two-beat notification frame (header, then command) and converts EDS/PMT "rx end" commands into stretched single-event pulses for the PCIe-side logic. It also keeps saturating good/bad frame counters for status readback.

---
 rtl/aurora_64b66b_rx.sv | 168 ++++++++++++++++
 tb/tb_aurora_64b66b_rx.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_64b66b_rx.sv
// aurora_64b66b_rx
//
// Receive-side parser for PCIe receive-end notifications carried over an Aurora 64B/66B
// AXI4-Stream RX user interface (no back-pressure: every valid beat is consumed).
// Each notification is a two-beat frame: a fixed header beat followed by a command beat.
// Command 1 produces an EDS rx-end event and command 2 a PMT rx-end event. Each event is
// stretched to PULSE_WIDTH cycles. Good and malformed frames are counted with saturation.
//
// Ports:
//   USER_CLK        Aurora user clock; all logic lives in this domain
//   RESET           synchronous, active-high reset (highest priority)
//   CHANNEL_UP      Aurora channel-up status; must be stable 16 cycles before parsing
//   rx_tvalid_i     beat valid
//   rx_tdata_i      beat data (64 bits)
//   rx_tkeep_i      byte enables; only 8'hFF counts as a well-formed beat
//   rx_tlast_i      last beat of frame
//   eds_rx_end_o    EDS receive-end event, high PULSE_WIDTH cycles
//   pmt_rx_end_o    PMT receive-end event, high PULSE_WIDTH cycles
//   frame_ok_cnt_o  saturating count of valid frames
//   frame_err_cnt_o saturating count of malformed frames
//   link_ready_o    channel qualified; beats are being parsed
//
// TCQ is accepted for compatibility with simulation-delay-style instantiations; the
// registers here are written without an explicit clock-to-Q delay.

module aurora_64b66b_rx #(
    parameter real         TCQ          = 0.1,
    parameter int unsigned PULSE_WIDTH  = 8,
    parameter logic [63:0] FRAME_HEADER = 64'h0000_0000_55AA_0001
) (
    input  logic        USER_CLK,
    input  logic        RESET,
    input  logic        CHANNEL_UP,
    input  logic        rx_tvalid_i,
    input  logic [63:0] rx_tdata_i,
    input  logic [7:0]  rx_tkeep_i,
    input  logic        rx_tlast_i,
    output logic        eds_rx_end_o,
    output logic        pmt_rx_end_o,
    output logic [15:0] frame_ok_cnt_o,
    output logic [15:0] frame_err_cnt_o,
    output logic        link_ready_o
);

    if (PULSE_WIDTH < 1 || PULSE_WIDTH > 255 || TCQ < 0.0) begin : g_param_check
        $error("aurora_64b66b_rx: PULSE_WIDTH must be 1..255 and TCQ non-negative");
    end

    localparam logic [7:0]  PW      = 8'(PULSE_WIDTH);
    localparam logic [63:0] CMD_EDS = 64'd1;
    localparam logic [63:0] CMD_PMT = 64'd2;

    typedef enum logic [2:0] {
        RX_IDLE = 3'b001,
        RX_CMD  = 3'b010,
        RX_DROP = 3'b100
    } rx_state_e;

    rx_state_e   r_state;
    rx_state_e   w_state_next;
    logic [4:0]  r_qual_cnt;
    logic [7:0]  r_eds_cnt;
    logic [7:0]  r_pmt_cnt;
    logic [15:0] r_ok_cnt;
    logic [15:0] r_err_cnt;

    logic        w_link_ok;
    logic        w_keep_ok;
    logic        w_eds_hit;
    logic        w_pmt_hit;
    logic        w_err_hit;

    // A CHANNEL_UP drop is honoured in the same cycle, before the qualifier clears.
    assign w_link_ok = r_qual_cnt[4] & CHANNEL_UP;
    assign w_keep_ok = (rx_tkeep_i == 8'hFF);

    always_comb begin
        w_state_next = r_state;
        w_eds_hit    = 1'b0;
        w_pmt_hit    = 1'b0;
        w_err_hit    = 1'b0;
        if (!w_link_ok) begin
            // Partial frames are silently discarded on channel loss.
            w_state_next = RX_IDLE;
        end else if (rx_tvalid_i) begin
            unique case (r_state)
                RX_IDLE: begin
                    if (rx_tlast_i) begin
                        w_err_hit = 1'b1;
                    end else if (w_keep_ok && rx_tdata_i == FRAME_HEADER) begin
                        w_state_next = RX_CMD;
                    end else begin
                        w_err_hit    = 1'b1;
                        w_state_next = RX_DROP;
                    end
                end
                RX_CMD: begin
                    if (rx_tlast_i) begin
                        w_state_next = RX_IDLE;
                        if (w_keep_ok && rx_tdata_i == CMD_EDS) begin
                            w_eds_hit = 1'b1;
                        end else if (w_keep_ok && rx_tdata_i == CMD_PMT) begin
                            w_pmt_hit = 1'b1;
                        end else begin
                            w_err_hit = 1'b1;
                        end
                    end else begin
                        w_err_hit    = 1'b1;
                        w_state_next = RX_DROP;
                    end
                end
                RX_DROP: begin
                    // Error already counted for this frame; just wait for its end.
                    if (rx_tlast_i) begin
                        w_state_next = RX_IDLE;
                    end
                end
                default: w_state_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            r_state    <= RX_IDLE;
            r_qual_cnt <= 5'd0;
            r_eds_cnt  <= 8'd0;
            r_pmt_cnt  <= 8'd0;
            r_ok_cnt   <= 16'd0;
            r_err_cnt  <= 16'd0;
        end else begin
            r_state <= w_state_next;

            if (!CHANNEL_UP) begin
                r_qual_cnt <= 5'd0;
            end else if (!r_qual_cnt[4]) begin
                r_qual_cnt <= r_qual_cnt + 5'd1;
            end

            if ((w_eds_hit || w_pmt_hit) && r_ok_cnt != 16'hFFFF) begin
                r_ok_cnt <= r_ok_cnt + 16'd1;
            end
            if (w_err_hit && r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end

            // A new event reloads the stretcher even while it is still running.
            if (w_eds_hit) begin
                r_eds_cnt <= PW;
            end else if (r_eds_cnt != 8'd0) begin
                r_eds_cnt <= r_eds_cnt - 8'd1;
            end

            if (w_pmt_hit) begin
                r_pmt_cnt <= PW;
            end else if (r_pmt_cnt != 8'd0) begin
                r_pmt_cnt <= r_pmt_cnt - 8'd1;
            end
        end
    end

    assign eds_rx_end_o    = (r_eds_cnt != 8'd0);
    assign pmt_rx_end_o    = (r_pmt_cnt != 8'd0);
    assign frame_ok_cnt_o  = r_ok_cnt;
    assign frame_err_cnt_o = r_err_cnt;
    assign link_ready_o    = r_qual_cnt[4];

endmodule

// File: tb/tb_aurora_64b66b_rx.sv
// Testbench for aurora_64b66b_rx: directed scenarios plus randomized frame streams, all
// checked against a frame-level reference model of the parser.

module tb_aurora_64b66b_rx;

    localparam int          PW  = 8;
    localparam logic [63:0] HDR = 64'h0000_0000_55AA_0001;

    typedef struct packed {
        logic        r;
        logic        cu;
        logic        v;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        chup;
    logic        valid;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        eds;
    logic        pmt;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;
    logic        ready;
    logic [34:0] obs;

    assign obs = {eds, pmt, ok_cnt, err_cnt, ready};

    aurora_64b66b_rx #(
        .TCQ          (0.1),
        .PULSE_WIDTH  (PW),
        .FRAME_HEADER (HDR)
    ) dut (
        .USER_CLK        (clk),
        .RESET           (rst),
        .CHANNEL_UP      (chup),
        .rx_tvalid_i     (valid),
        .rx_tdata_i      (data),
        .rx_tkeep_i      (keep),
        .rx_tlast_i      (last),
        .eds_rx_end_o    (eds),
        .pmt_rx_end_o    (pmt),
        .frame_ok_cnt_o  (ok_cnt),
        .frame_err_cnt_o (err_cnt),
        .link_ready_o    (ready)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int cyc = 0;
    int m_up = 0;          // consecutive CHANNEL_UP edges, capped at 16
    int m_nbeats = 0;      // beats of the current frame accepted as good so far
    bit m_dead = 1'b0;     // current frame already counted as bad
    int m_ok = 0;
    int m_err = 0;
    int m_eds_last = -1;   // last sample index at which EDS must be high
    int m_pmt_last = -1;

    int n_vec = 0;
    int n_fail = 0;

    beat_t q[$];

    function automatic beat_t mk(input logic r, input logic cu, input logic v,
                                 input logic [63:0] d, input logic [7:0] k, input logic l);
        beat_t b;
        b.r = r; b.cu = cu; b.v = v; b.d = d; b.k = k; b.l = l;
        return b;
    endfunction

    task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
        q.push_back(mk(1'b0, 1'b1, 1'b1, d, k, l));
    endtask

    task automatic idle(input int n, input logic cu);
        for (int i = 0; i < n; i++) q.push_back(mk(1'b0, cu, 1'b0, 64'd0, 8'd0, 1'b0));
    endtask

    task automatic reset_and_qualify();
        q.push_back(mk(1'b1, 1'b1, 1'b0, 64'd0, 8'd0, 1'b0));
        idle(20, 1'b1);
    endtask

    // Frame rules: a good frame is exactly [header, keep FF, not last] followed by
    // [1 or 2, keep FF, last]. The first beat that cannot belong to such a frame marks
    // it bad (counted once); remaining beats are skipped until tlast.
    task automatic model_edge(input beat_t b);
        bit link_ok;
        if (b.r) begin
            m_up = 0; m_nbeats = 0; m_dead = 1'b0; m_ok = 0; m_err = 0;
            m_eds_last = -1; m_pmt_last = -1;
        end else begin
            link_ok = b.cu && (m_up >= 16);
            if (!link_ok) begin
                m_nbeats = 0;
                m_dead   = 1'b0;
            end else if (b.v) begin
                if (m_dead) begin
                    if (b.l) m_dead = 1'b0;
                end else if (m_nbeats == 0 && !b.l && b.k == 8'hFF && b.d == HDR) begin
                    m_nbeats = 1;
                end else if (m_nbeats == 1 && b.l && b.k == 8'hFF &&
                             (b.d == 64'd1 || b.d == 64'd2)) begin
                    if (m_ok < 65535) m_ok++;
                    if (b.d == 64'd1) m_eds_last = cyc + PW - 1;
                    else              m_pmt_last = cyc + PW - 1;
                    m_nbeats = 0;
                end else begin
                    if (m_err < 65535) m_err++;
                    m_nbeats = 0;
                    m_dead   = !b.l;
                end
            end
            m_up = b.cu ? ((m_up < 16) ? m_up + 1 : 16) : 0;
        end
    endtask

    function automatic logic [34:0] expected();
        logic [15:0] ok16;
        logic [15:0] err16;
        ok16  = 16'(m_ok);
        err16 = 16'(m_err);
        return {cyc <= m_eds_last, cyc <= m_pmt_last, ok16, err16, m_up >= 16};
    endfunction

    // Applies one beat at the next rising edge, then returns at the falling edge.
    task automatic drive(input beat_t b);
        rst = b.r; chup = b.cu; valid = b.v; data = b.d; keep = b.k; last = b.l;
        @(posedge clk);
        cyc++;
        model_edge(b);
        @(negedge clk);
    endtask

    task automatic test_reset();
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back(mk(1'b1, 1'b1, 1'b1, HDR, 8'hFF, 1'b0));
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if (obs !== 35'd0) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs, 35'd0);
            end
        end
    endtask

    task automatic test_good_eds();
        int i_cmd;
        int first_hi;
        int n_hi;
        bit pmt_seen;
        q.delete();
        reset_and_qualify();
        push(HDR, 8'hFF, 1'b0);
        i_cmd = q.size();
        push(64'd1, 8'hFF, 1'b1);
        idle(12, 1'b1);
        first_hi = -1; n_hi = 0; pmt_seen = 1'b0;
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if (obs !== expected()) begin
                n_fail++;
                $display("FAIL good_eds cyc=%0d got=%h want=%h", cyc, obs, expected());
            end
            if (eds === 1'b1) begin
                n_hi++;
                if (first_hi < 0) first_hi = i;
            end
            if (pmt !== 1'b0) pmt_seen = 1'b1;
        end
        n_vec++;
        if (first_hi != i_cmd || n_hi != PW || pmt_seen) begin
            n_fail++;
            $display("FAIL good_eds_pulse got start=%0d len=%0d pmt=%0d want start=%0d len=%0d pmt=0",
                     first_hi, n_hi, pmt_seen, i_cmd, PW);
        end
        n_vec++;
        if (ok_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL good_eds_ok got=%0d want=1", ok_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n_both;
        q.delete();
        reset_and_qualify();
        push(HDR, 8'hFF, 1'b0);
        push(64'd2, 8'hFF, 1'b1);
        push(HDR, 8'hFF, 1'b0);
        push(64'd1, 8'hFF, 1'b1);
        idle(12, 1'b1);
        n_both = 0;
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if (obs !== expected()) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, obs, expected());
            end
            if (eds === 1'b1 && pmt === 1'b1) n_both++;
        end
        n_vec++;
        if (n_both != PW - 2 || ok_cnt !== 16'd2 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL back_to_back_sum got overlap=%0d ok=%0d err=%0d want %0d/2/0",
                     n_both, ok_cnt, err_cnt, PW - 2);
        end
    endtask

    task automatic test_malformed();
        int n_eds;
        q.delete();
        reset_and_qualify();
        push(64'h55AA_0002, 8'hFF, 1'b0); push(64'd1, 8'hFF, 1'b1);   // bad header
        push(HDR, 8'hFF, 1'b0);           push(64'd3, 8'hFF, 1'b1);   // bad command
        push(HDR, 8'hFF, 1'b0);           push(64'd1, 8'hFF, 1'b0);   // three beats
        push(64'd2, 8'hFF, 1'b1);
        push(HDR, 8'hFF, 1'b1);                                       // single beat
        push(HDR, 8'hFF, 1'b0);           push(64'd1, 8'h0F, 1'b1);   // partial keep
        idle(3, 1'b1);
        push(HDR, 8'hFF, 1'b0);           push(64'd1, 8'hFF, 1'b1);   // good
        idle(10, 1'b1);
        n_eds = 0;
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if (obs !== expected()) begin
                n_fail++;
                $display("FAIL malformed cyc=%0d got=%h want=%h", cyc, obs, expected());
            end
            if (eds === 1'b1) n_eds++;
        end
        n_vec++;
        if (err_cnt !== 16'd5 || ok_cnt !== 16'd1 || n_eds != PW) begin
            n_fail++;
            $display("FAIL malformed_sum got err=%0d ok=%0d eds_cycles=%0d want 5/1/%0d",
                     err_cnt, ok_cnt, n_eds, PW);
        end
    endtask

    task automatic test_qualification();
        q.delete();
        q.push_back(mk(1'b1, 1'b1, 1'b0, 64'd0, 8'd0, 1'b0));
        idle(10, 1'b1);
        push(HDR, 8'hFF, 1'b0);
        push(64'd1, 8'hFF, 1'b1);
        idle(10, 1'b1);
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if (obs !== expected()) begin
                n_fail++;
                $display("FAIL qual_early cyc=%0d got=%h want=%h", cyc, obs, expected());
            end
        end
        n_vec++;
        if (ok_cnt !== 16'd0 || err_cnt !== 16'd0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL qual_early_sum got ok=%0d err=%0d ready=%0d want 0/0/1",
                     ok_cnt, err_cnt, ready);
        end
        // Header, channel loss, then a command beat before requalification.
        q.delete();
        push(HDR, 8'hFF, 1'b0);
        idle(1, 1'b0);
        idle(5, 1'b1);
        push(64'd1, 8'hFF, 1'b1);
        idle(20, 1'b1);
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if (obs !== expected()) begin
                n_fail++;
                $display("FAIL qual_drop cyc=%0d got=%h want=%h", cyc, obs, expected());
            end
        end
        n_vec++;
        if (ok_cnt !== 16'd0 || err_cnt !== 16'd0 || eds !== 1'b0) begin
            n_fail++;
            $display("FAIL qual_drop_sum got ok=%0d err=%0d eds=%0d want 0/0/0",
                     ok_cnt, err_cnt, eds);
        end
        // Parser must be back in idle: a fresh good frame is accepted.
        q.delete();
        push(HDR, 8'hFF, 1'b0);
        push(64'd1, 8'hFF, 1'b1);
        idle(2, 1'b1);
        foreach (q[i]) drive(q[i]);
        n_vec++;
        if (ok_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL qual_recover got ok=%0d err=%0d want 1/0", ok_cnt, err_cnt);
        end
    endtask

    task automatic test_retrigger();
        int run;
        int best;
        int n_hi;
        q.delete();
        reset_and_qualify();
        push(HDR, 8'hFF, 1'b0);
        push(64'd1, 8'hFF, 1'b1);
        idle(1, 1'b1);
        push(HDR, 8'hFF, 1'b0);
        push(64'd1, 8'hFF, 1'b1);
        idle(15, 1'b1);
        run = 0; best = 0; n_hi = 0;
        foreach (q[i]) begin
            drive(q[i]);
            n_vec++;
            if (obs !== expected()) begin
                n_fail++;
                $display("FAIL retrigger cyc=%0d got=%h want=%h", cyc, obs, expected());
            end
            if (eds === 1'b1) begin
                run++; n_hi++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        n_vec++;
        if (best != 3 + PW || n_hi != 3 + PW) begin
            n_fail++;
            $display("FAIL retrigger_len got run=%0d total=%0d want %0d", best, n_hi, 3 + PW);
        end
    endtask

    task automatic push_gaps();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            q.push_back(mk(1'b0, 1'b1, 1'b0, {$urandom, $urandom}, 8'($urandom),
                           1'($urandom)));
        end
    endtask

    function automatic logic [7:0] rkeep();
        return ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 254)) : 8'hFF;
    endfunction

    task automatic test_random();
        int kind;
        q.delete();
        reset_and_qualify();
        for (int f = 0; f < 250; f++) begin
            kind = $urandom_range(0, 9);
            push_gaps();
            case (kind)
                0, 1, 2: begin
                    push(HDR, rkeep(), 1'b0); push_gaps(); push(64'd1, rkeep(), 1'b1);
                end
                3, 4: begin
                    push(HDR, rkeep(), 1'b0); push_gaps(); push(64'd2, rkeep(), 1'b1);
                end
                5: begin
                    push({$urandom, $urandom}, 8'hFF, 1'b0); push_gaps();
                    push(64'd1, 8'hFF, 1'b1);
                end
                6: begin
                    push(HDR, 8'hFF, 1'b0); push_gaps();
                    push(64'($urandom_range(3, 20)), 8'hFF, 1'b1);
                end
                7: begin
                    push(HDR, 8'hFF, 1'b0); push(64'd1, 8'hFF, 1'b0); push_gaps();
                    push({$urandom, $urandom}, rkeep(), 1'b1);
                end
                8: push(($urandom_range(0, 1) == 0) ? HDR : 64'd1, rkeep(), 1'b1);
                default: begin
                    push(HDR, 8'hFF, 1'b0); push(HDR, 8'hFF, 1'b0); push(64'd1, 8'hFF, 1'b1);
                end
            endcase
        end
        foreach (q[i]) begin
            if ($urandom_range(0, 149) == 0) q[i].cu = 1'b0;
            drive(q[i]);
            n_vec++;
            if (obs !== expected()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, expected());
            end
        end
    endtask

    task automatic test_saturation();
        beat_t b;
        q.delete();
        reset_and_qualify();
        foreach (q[i]) drive(q[i]);
        for (int i = 0; i < 65537; i++) begin
            b = mk(1'b0, 1'b1, 1'b1, {$urandom, $urandom}, 8'hFF, 1'b1);
            drive(b);
        end
        n_vec++;
        if (err_cnt !== 16'hFFFF || obs !== expected()) begin
            n_fail++;
            $display("FAIL saturate got err=%h obs=%h want err=ffff obs=%h",
                     err_cnt, obs, expected());
        end
        q.delete();
        push(64'd7, 8'hFF, 1'b1);
        push(64'd7, 8'hFF, 1'b1);
        push(HDR, 8'hFF, 1'b0);
        push(64'd2, 8'hFF, 1'b1);
        foreach (q[i]) drive(q[i]);
        n_vec++;
        if (err_cnt !== 16'hFFFF || ok_cnt !== 16'd1 || pmt !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate_hold got err=%h ok=%0d pmt=%0d want ffff/1/1",
                     err_cnt, ok_cnt, pmt);
        end
    endtask

    task automatic test_reset_mid_pulse();
        q.delete();
        push(HDR, 8'hFF, 1'b0);
        push(64'd2, 8'hFF, 1'b1);
        push(HDR, 8'hFF, 1'b0);
        push(64'd1, 8'hFF, 1'b1);
        idle(2, 1'b1);
        foreach (q[i]) drive(q[i]);
        n_vec++;
        if (eds !== 1'b1 || pmt !== 1'b1 || obs !== expected()) begin
            n_fail++;
            $display("FAIL pre_reset_pulses got=%h want=%h", obs, expected());
        end
        drive(mk(1'b1, 1'b1, 1'b1, HDR, 8'hFF, 1'b0));
        n_vec++;
        if (obs !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_mid_pulse got=%h want=%h", obs, 35'd0);
        end
    endtask

    initial begin
        rst = 1'b1; chup = 1'b0; valid = 1'b0; data = 64'd0; keep = 8'd0; last = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_eds();
        test_back_to_back();
        test_malformed();
        test_qualification();
        test_retrigger();
        test_random();
        test_saturation();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
